ldpc_ram_reader: RTL and testbench

Read-side initiator for the LDPC decoder's on-chip RAM. It accepts a burst command (base address, length) and issues sequential read addresses on the RAM's address valid/ready port. It collects the returned data on the RAM's data valid/ready port and forwards it as a framed stream with a last flag to the decoder datapath. Outstanding requests are tracked so that the RAM's 4-deep response skid can never overflow.

---
 rtl/ldpc_ram_pkg.sv | 8 +
 rtl/ldpc_skid_fifo.sv | 41 ++++
 rtl/ldpc_ram_reader.sv | 103 ++++++++++
 tb/tb_ldpc_ram_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_ram_pkg.sv
// ldpc_ram_pkg: shared state type, RAM constants and address helper for the LDPC RAM reader
package ldpc_ram_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int RAM_SKID_DEPTH = 4;
    function automatic int unsigned addr_inc(input int unsigned a, input int unsigned depth);
        return (a + 1 >= depth) ? 0 : a + 1;
    endfunction
endpackage

// File: rtl/ldpc_skid_fifo.sv
// ldpc_skid_fifo: 2-entry valid/ready FIFO whose input ready is registered as "not full next cycle"
module ldpc_skid_fifo #(
    parameter int W = 9
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);
    logic [W-1:0] r_mem [2];
    logic         r_wr, r_rd;
    logic [1:0]   r_count;
    logic [1:0]   w_count_nxt;
    logic         w_push, w_pop;
    assign w_push      = i_valid && o_ready;
    assign w_pop       = o_valid && i_ready;
    assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
    assign o_valid     = r_count != 2'd0;
    assign o_data      = r_mem[r_rd];
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_mem   <= '{default: '0};
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
            o_ready <= 1'b1;
        end else begin
            if (w_push) r_mem[r_wr] <= i_data;
            r_wr    <= r_wr ^ w_push;
            r_rd    <= r_rd ^ w_pop;
            r_count <= w_count_nxt;
            o_ready <= w_count_nxt != 2'd2;
        end
    end
    always_ff @(posedge i_clock)
        if (!i_reset) assert (!(w_push && r_count == 2'd2));
endmodule

// File: rtl/ldpc_ram_reader.sv
// ldpc_ram_reader: issues sequential RAM read addresses for a burst command and streams the
// returned words out with a last flag, never exceeding the RAM response skid depth in flight.
module ldpc_ram_reader
    import ldpc_ram_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 1024,
    parameter int MAX_OUTSTANDING = 4,
    localparam int AW             = $clog2(DEPTH),
    localparam int LW             = AW + 1,
    localparam int OW             = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [AW-1:0]    i_cmd_base,
    input  logic [LW-1:0]    i_cmd_len,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    output logic [AW-1:0]    o_ram_addr,
    output logic             o_ram_addr_valid,
    input  logic             i_ram_addr_ready,
    input  logic [WIDTH-1:0] i_ram_data,
    input  logic             i_ram_valid,
    output logic             o_ram_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_last,
    input  logic             i_ready,
    output logic             o_busy
);
    localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] SKID = OW'(RAM_SKID_DEPTH);
    state_t        r_state;
    logic [LW-1:0] r_issue_rem, r_recv_rem;
    logic [OW-1:0] r_outst;
    logic [OW-1:0] w_outst_nxt;
    logic [LW-1:0] w_issue_nxt;
    logic          w_addr_hs, w_data_hs, w_out_hs;
    logic [WIDTH:0] w_head;
    assign w_addr_hs   = o_ram_addr_valid && i_ram_addr_ready;
    assign w_data_hs   = i_ram_valid && o_ram_ready;
    assign w_out_hs    = o_valid && i_ready;
    assign w_outst_nxt = r_outst + OW'(w_addr_hs) - OW'(w_data_hs);
    assign w_issue_nxt = r_issue_rem - LW'(w_addr_hs);
    assign o_data      = w_head[WIDTH:1];
    assign o_last      = w_head[0] && o_valid;
    // The address valid is registered, so the in-flight limit is judged on next-cycle counts.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_issue_rem      <= '0;
            r_recv_rem       <= '0;
            r_outst          <= '0;
            o_cmd_ready      <= 1'b1;
            o_ram_addr       <= '0;
            o_ram_addr_valid <= 1'b0;
            o_busy           <= 1'b0;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_data_hs) r_recv_rem <= r_recv_rem - LW'(1);
            case (r_state)
                IDLE: if (i_cmd_valid && o_cmd_ready && i_cmd_len != '0) begin
                    r_state          <= ISSUE;
                    o_ram_addr       <= i_cmd_base;
                    r_issue_rem      <= i_cmd_len;
                    r_recv_rem       <= i_cmd_len;
                    o_ram_addr_valid <= 1'b1;
                    o_cmd_ready      <= 1'b0;
                    o_busy           <= 1'b1;
                end
                ISSUE: begin
                    if (w_addr_hs) begin
                        o_ram_addr  <= AW'(addr_inc(32'(o_ram_addr), DEPTH));
                        r_issue_rem <= w_issue_nxt;
                    end
                    o_ram_addr_valid <= (w_issue_nxt != '0) && (w_outst_nxt < MAXO);
                    if (w_issue_nxt == '0) r_state <= DRAIN;
                end
                DRAIN: if (w_out_hs && o_last) begin
                    r_state     <= IDLE;
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clock)
        if (!i_reset) begin
            assert (r_outst <= MAXO && r_outst <= SKID);
            assert (!(r_outst == '0 && w_data_hs && !w_addr_hs));
        end
    ldpc_skid_fifo #(.W(WIDTH + 1)) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_data  ({i_ram_data, r_recv_rem == LW'(1)}),
        .i_valid (i_ram_valid),
        .o_ready (o_ram_ready),
        .o_data  (w_head),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );
endmodule

// File: tb/tb_ldpc_ram_reader.sv
// tb_ldpc_ram_reader: directed bench with a RAM latency model and output scoreboard
module tb_ldpc_ram_reader;
    localparam int DEPTH = 1024;
    logic       i_clock, i_reset;
    logic [9:0] i_cmd_base;
    logic [10:0] i_cmd_len;
    logic       i_cmd_valid, o_cmd_ready;
    logic [9:0] o_ram_addr;
    logic       o_ram_addr_valid, i_ram_addr_ready;
    logic [7:0] i_ram_data;
    logic       i_ram_valid, o_ram_ready;
    logic [7:0] o_data;
    logic       o_valid, o_last, i_ready, o_busy;

    ldpc_ram_reader dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_cmd_base(i_cmd_base), .i_cmd_len(i_cmd_len), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .o_ram_addr(o_ram_addr), .o_ram_addr_valid(o_ram_addr_valid), .i_ram_addr_ready(i_ram_addr_ready),
        .i_ram_data(i_ram_data), .i_ram_valid(i_ram_valid), .o_ram_ready(o_ram_ready),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready), .o_busy(o_busy)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    int n_tests = 0, n_fail = 0;
    int cyc = 0, lat = 2, ocnt = 0, peak = 0, gpeak = 0, gmin = 0, n_last = 0, hold_err = 0;
    bit rnd = 0, hold = 0, cmd_acc = 0, any_valid = 0, pend_a = 0, pend_o = 0;
    int pend_addr;
    logic [8:0] pend_word;
    int rq[$], rdue[$], alog[$], exp_a[$];
    logic [8:0] got[$], exp_q[$];

    function automatic logic [7:0] ddata(input int a);
        return 8'(a * 7 + 3 + (a >> 8));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Handshakes are logged mid-cycle, just before the edge that completes them.
    task automatic tick();
        if (!i_reset) begin
            if (pend_a && (!o_ram_addr_valid || int'(o_ram_addr) != pend_addr)) hold_err++;
            if (pend_o && (!o_valid || {o_data, o_last} !== pend_word)) hold_err++;
            pend_a = o_ram_addr_valid && !i_ram_addr_ready;
            pend_addr = int'(o_ram_addr);
            pend_o = o_valid && !i_ready;
            pend_word = {o_data, o_last};
            if (i_cmd_valid && o_cmd_ready) cmd_acc = 1;
            if (i_ram_valid && o_ram_ready) begin
                void'(rq.pop_front());
                void'(rdue.pop_front());
                ocnt--;
            end
            if (o_ram_addr_valid && i_ram_addr_ready) begin
                alog.push_back(int'(o_ram_addr));
                rq.push_back(int'(o_ram_addr));
                rdue.push_back(cyc + 1 + (rnd ? int'($urandom_range(1, 4)) : lat));
                ocnt++;
            end
            if (o_valid && i_ready) begin
                got.push_back({o_data, o_last});
                if (o_last) n_last++;
            end
            if (o_valid) any_valid = 1;
            if (ocnt > peak) peak = ocnt;
            if (ocnt > gpeak) gpeak = ocnt;
            if (ocnt < gmin) gmin = ocnt;
        end
        @(posedge i_clock);
        cyc++;
        @(negedge i_clock);
        i_ram_addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        i_ready = hold ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_ram_valid = rq.size() > 0 && rdue[0] <= cyc;
        i_ram_data = rq.size() > 0 ? ddata(rq[0]) : 8'h00;
    endtask

    task automatic clr();
        got.delete(); exp_q.delete(); alog.delete(); exp_a.delete();
        n_last = 0; peak = 0; any_valid = 0;
    endtask

    task automatic add_exp(input int base, input int len);
        for (int k = 0; k < len; k++) begin
            exp_a.push_back((base + k) % DEPTH);
            exp_q.push_back({ddata((base + k) % DEPTH), 1'(k == len - 1)});
        end
    endtask

    task automatic start_cmd(input int base, input int len);
        int n = 0;
        add_exp(base, len);
        i_cmd_base = 10'(base);
        i_cmd_len = 11'(len);
        i_cmd_valid = 1'b1;
        cmd_acc = 0;
        while (!cmd_acc && n < 4000) begin tick(); n++; end
        i_cmd_valid = 1'b0;
        chk("cmd accepted", 32'(cmd_acc), 1);
    endtask

    task automatic finish_to(input int target, input string tag);
        int n = 0, mism = 0, amism = 0;
        while (n_last < target && n < 4000) begin tick(); n++; end
        chk({tag, ".last_seen"}, n_last, target);
        chk({tag, ".busy_drop"}, 32'(o_busy), 0);
        chk({tag, ".cmd_ready"}, 32'(o_cmd_ready), 1);
        chk({tag, ".words"}, got.size(), exp_q.size());
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) if (got[k] !== exp_q[k]) mism++;
        chk({tag, ".data"}, mism, 0);
        chk({tag, ".naddr"}, alog.size(), exp_a.size());
        for (int k = 0; k < alog.size() && k < exp_a.size(); k++) if (alog[k] != exp_a[k]) amism++;
        chk({tag, ".addrs"}, amism, 0);
    endtask

    initial begin
        int n, early, acc_last;
        logic [7:0] d0;
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_base = '0; i_cmd_len = '0;
        i_ram_addr_ready = 1'b1; i_ram_data = '0; i_ram_valid = 1'b0; i_ready = 1'b1;
        repeat (2) @(negedge i_clock);
        chk("rst.cmd_ready", 32'(o_cmd_ready), 1);
        chk("rst.addr_valid", 32'(o_ram_addr_valid), 0);
        chk("rst.addr", 32'(o_ram_addr), 0);
        chk("rst.ram_ready", 32'(o_ram_ready), 1);
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.last", 32'(o_last), 0);
        chk("rst.busy", 32'(o_busy), 0);
        i_reset = 1'b0;
        tick();

        clr();
        start_cmd(10, 5);
        chk("basic.first_addr_valid", 32'(o_ram_addr_valid), 1);
        chk("basic.first_addr", 32'(o_ram_addr), 10);
        chk("basic.busy", 32'(o_busy), 1);
        chk("basic.cmd_ready_low", 32'(o_cmd_ready), 0);
        finish_to(1, "basic");

        clr();
        start_cmd(1022, 4);
        finish_to(1, "wrap");
        chk("wrap.third_addr", alog.size() > 2 ? alog[2] : -1, 0);

        clr();
        hold = 1;
        start_cmd(256, 16);
        repeat (10) tick();
        d0 = o_data;
        repeat (10) tick();
        chk("bp.addr_valid_off", 32'(o_ram_addr_valid), 0);
        chk("bp.peak", peak, 4);
        chk("bp.head_valid", 32'(o_valid), 1);
        chk("bp.head_data", 32'(o_data), 32'(ddata(256)));
        chk("bp.head_stable", 32'(o_data), 32'(d0));
        hold = 0;
        finish_to(1, "bp");

        clr();
        start_cmd(7, 0);
        chk("zero.busy", 32'(o_busy), 0);
        repeat (8) tick();
        chk("zero.no_addr", alog.size(), 0);
        chk("zero.no_valid", 32'(any_valid), 0);
        chk("zero.cmd_ready", 32'(o_cmd_ready), 1);

        clr();
        start_cmd(100, 6);
        add_exp(200, 3);
        i_cmd_base = 10'd200; i_cmd_len = 11'd3; i_cmd_valid = 1'b1;
        cmd_acc = 0; n = 0; early = 0;
        while (!cmd_acc && n < 4000) begin
            if (o_cmd_ready && n_last == 0) early++;
            tick(); n++;
        end
        acc_last = n_last;
        i_cmd_valid = 1'b0;
        chk("stall.accepted", 32'(cmd_acc), 1);
        chk("stall.no_early_ready", early, 0);
        chk("stall.after_first", acc_last, 1);
        finish_to(2, "stall");

        clr();
        start_cmd(80, 8);
        n = 0;
        while (got.size() < 2 && n < 200) begin tick(); n++; end
        #2 i_reset = 1'b1;
        #1;
        chk("arst.cmd_ready", 32'(o_cmd_ready), 1);
        chk("arst.addr_valid", 32'(o_ram_addr_valid), 0);
        chk("arst.addr", 32'(o_ram_addr), 0);
        chk("arst.valid", 32'(o_valid), 0);
        chk("arst.busy", 32'(o_busy), 0);
        chk("arst.ram_ready", 32'(o_ram_ready), 1);
        rq.delete(); rdue.delete(); ocnt = 0; i_ram_valid = 1'b0; pend_a = 0; pend_o = 0;
        tick();
        i_reset = 1'b0;
        clr();
        start_cmd(0, 2);
        finish_to(1, "post_rst");

        rnd = 1;
        for (int b = 0; b < 300; b++) begin
            clr();
            start_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)));
            finish_to(1, "rand");
        end
        rnd = 0;
        chk("outstanding_max", gpeak, 4);
        chk("outstanding_min", gmin, 0);
        chk("handshake_hold", hold_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
